// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
//   seq_state_t : sequencer FSM states
//   SPI_ADDR_W  : SPI register address width
//   SPI_LEN_W   : transaction length width (bits on the wire)
//   nwords()    : number of 32-bit FIFO words needed for a given bit length
package spi_seq_pkg;

   localparam int unsigned SPI_ADDR_W = 10;
   localparam int unsigned SPI_LEN_W  = 8;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      SETUP,
      START,
      WAIT_DONE,
      CLEAR,
      RD_REQ,
      RD_DATA,
      RD_RSP,
      FLUSH,
      RESP_OK,
      RESP_ERR
   } seq_state_t;

   // ceil(len / 32); 1..8 for any nonzero 8-bit length.
   function automatic logic [4:0] nwords(input logic [SPI_LEN_W-1:0] len);
      logic [SPI_LEN_W:0] sum;
      sum = {1'b0, len} + (SPI_LEN_W + 1)'(31);
      return {1'b0, sum[SPI_LEN_W:5]};
   endfunction

endpackage

// File: rtl/spi_transaction_sequencer.sv
// Runs one complete SPI transaction per descriptor against spi_controller_SP3.
// Write: stream nwords words into the command FIFO, program WnR/address, start the
// controller, wait for done, return one status beat. Read: program, start, wait for
// done, then pop the read FIFO one word at a time and return each word as a beat.
// Timeouts and zero-length requests end with a single error beat (after the read FIFO
// has been drained).
// Ports:
//   axi_clk, reset                        clock, synchronous active-high reset
//   req_*                                 descriptor and write-word streams from upstream
//   rsp_*                                 response beats to upstream
//   spi_command_wr_en/din/full            command (write data) FIFO
//   spi_read_rd_en/dout/empty             read data FIFO (dout valid the cycle after rd_en)
//   WnR, spi_address, spi_data_len, done  controller interface
//   busy                                  sequencer not idle
module spi_transaction_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
   input  logic                          axi_clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_WnR,
   input  logic [SPI_ADDR_W-1:0]         req_address,
   input  logic [SPI_LEN_W-1:0]          req_data_len,
   input  logic                          req_wdata_valid,
   output logic                          req_wdata_ready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
   output logic                          rsp_last,
   output logic                          rsp_error,
   output logic                          spi_command_wr_en,
   output logic [C_S_AXI_DATA_WIDTH-1:0] spi_command_din,
   input  logic                          spi_command_full,
   output logic                          spi_read_rd_en,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] spi_read_dout,
   input  logic                          spi_read_empty,
   output logic                          WnR,
   output logic [SPI_ADDR_W-1:0]         spi_address,
   output logic [SPI_LEN_W-1:0]          spi_data_len,
   input  logic                          done,
   output logic                          busy
);

   seq_state_t                    state_q, state_d;
   logic                          wnr_q, wnr_d;
   logic [SPI_ADDR_W-1:0]         addr_q, addr_d;
   logic [SPI_LEN_W-1:0]          len_q, len_d;
   logic [4:0]                    nw_q, nw_d;
   logic [4:0]                    cnt_q, cnt_d;      // pushes in LOAD, beats in RD_RSP
   logic [31:0]                   tmo_q, tmo_d;
   logic                          err_q, err_d;
   logic                          ctl_q, ctl_d;      // WnR/address presented to controller
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                          beat_last;
   logic                          tmo_hit;

   assign beat_last = (cnt_q + 5'd1) == nw_q;
   assign tmo_hit   = tmo_q == 32'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge axi_clk) begin
      if (reset) begin
         state_q <= IDLE;
         wnr_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         nw_q    <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         ctl_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wnr_q   <= wnr_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         nw_q    <= nw_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         ctl_q   <= ctl_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      wnr_d             = wnr_q;
      addr_d            = addr_q;
      len_d             = len_q;
      nw_d              = nw_q;
      cnt_d             = cnt_q;
      tmo_d             = tmo_q;
      err_d             = err_q;
      rdata_d           = rdata_q;
      req_ready         = 1'b0;
      req_wdata_ready   = 1'b0;
      spi_command_wr_en = 1'b0;
      spi_read_rd_en    = 1'b0;
      rsp_valid         = 1'b0;
      rsp_last          = 1'b0;
      rsp_error         = 1'b0;
      rsp_rdata         = '0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               wnr_d  = req_WnR;
               addr_d = req_address;
               len_d  = req_data_len;
               nw_d   = nwords(req_data_len);
               cnt_d  = '0;
               tmo_d  = '0;
               err_d  = 1'b0;
               if (req_data_len == '0) state_d = RESP_ERR;
               else if (req_WnR)       state_d = LOAD;
               else                    state_d = SETUP;
            end
         end
         LOAD: begin
            req_wdata_ready = !spi_command_full;
            if (req_wdata_valid && !spi_command_full) begin
               spi_command_wr_en = 1'b1;
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = SETUP;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         SETUP: state_d = START;
         START: begin
            tmo_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done) begin
               tmo_d   = '0;
               state_d = CLEAR;
            end else if (tmo_hit) begin
               tmo_d   = '0;
               err_d   = 1'b1;
               state_d = CLEAR;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         CLEAR: begin
            if (!done) begin
               if (err_q)      state_d = FLUSH;
               else if (wnr_q) state_d = RESP_OK;
               else            state_d = RD_REQ;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = FLUSH;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         RD_REQ: begin
            if (!spi_read_empty) begin
               spi_read_rd_en = 1'b1;
               state_d        = RD_DATA;
            end
         end
         RD_DATA: begin
            rdata_d = spi_read_dout;
            state_d = RD_RSP;
         end
         RD_RSP: begin
            rsp_valid = 1'b1;
            rsp_last  = beat_last;
            rsp_rdata = rdata_q;
            if (rsp_ready) begin
               if (beat_last) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = cnt_q + 5'd1;
                  state_d = RD_REQ;
               end
            end
         end
         FLUSH: begin
            // Drop whatever the aborted transfer left behind so the next read starts clean.
            if (spi_read_empty) state_d = RESP_ERR;
            else                spi_read_rd_en = 1'b1;
         end
         RESP_OK: begin
            rsp_valid = 1'b1;
            rsp_last  = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         RESP_ERR: begin
            rsp_valid = 1'b1;
            rsp_last  = 1'b1;
            rsp_error = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ctl_d = ctl_q;
      if (state_q == SETUP) ctl_d = 1'b1;
      if (state_d == IDLE)  ctl_d = 1'b0;
   end

   assign spi_command_din = spi_command_wr_en ? req_wdata : '0;
   assign WnR             = (ctl_q || state_q == SETUP) ? wnr_q : 1'b0;
   assign spi_address     = (ctl_q || state_q == SETUP) ? addr_q : '0;
   // A nonzero length is the controller's start strobe; it is dropped in CLEAR.
   assign spi_data_len    = (state_q == START || state_q == WAIT_DONE) ? len_q : '0;
   assign busy            = state_q != IDLE;

endmodule
